// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// opcode/funct constants, ALU control codes and datapath mux encodings.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ASB_REG = 2'b00;
    localparam logic [1:0] ASB_ONE = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder.
//   funct       in  6  Instruction[5:0]
//   alu_ctrl    out 4  ALU operation code (0000 when funct is unsupported)
//   funct_valid out 1  funct is one of ADD/SUB/AND/OR/SLT
module mips_alu_decode
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        alu_ctrl    = '0;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with a shared instruction/data memory.
//   clk, rst (async, active high)
//   opcode, funct, zero          : instruction fields and ALU zero flag
//   mem_ready                    : memory completes the access this cycle
//   mem_req, mem_we, iord        : memory handshake and address select
//   ir_write, pc_write, pc_src   : IR/PC load controls
//   reg_write, reg_dst, mem_to_reg : register file write controls
//   alu_src_a, alu_src_b, alu_ctrl : ALU operand selects and operation
//   retire                       : pulse in the last state of an instruction
//   illegal                      : sticky trap flag
//   state                        : current FSM state (debug)
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    // Trap fires on the cycle the counter would reach WAIT_LIMIT.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    state_t           cur;
    logic [CNT_W-1:0] wait_cnt;
    logic             illegal_q;
    logic [3:0]       r_alu_ctrl;
    logic             funct_valid;

    mips_alu_decode u_alu_decode (
        .funct      (funct),
        .alu_ctrl   (r_alu_ctrl),
        .funct_valid(funct_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (cur)
                S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
                    if (mem_ready) begin
                        if (cur == S_FETCH)         cur <= S_DECODE;
                        else if (cur == S_MEM_READ) cur <= S_MEM_WB;
                        else                        cur <= S_FETCH;
                    end else if (wait_cnt == LIMIT_M1) begin
                        cur       <= S_TRAP;
                        illegal_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:      cur <= S_R_EXEC;
                        OP_LW, OP_SW:  cur <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE: cur <= S_BRANCH;
                        OP_J:          cur <= S_JUMP;
                        OP_ADDI:       cur <= S_I_EXEC;
                        default: begin
                            cur       <= S_TRAP;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: cur <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_R_EXEC: begin
                    if (funct_valid) begin
                        cur <= S_R_WB;
                    end else begin
                        cur       <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_I_EXEC: cur <= S_I_WB;
                S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: cur <= S_FETCH;
                S_TRAP:   cur <= S_TRAP;
                default: begin
                    cur       <= S_TRAP;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    assign state   = cur;
    assign illegal = illegal_q;

    // Decoded outputs are gated by rst so an access in flight (e.g. a store)
    // is withdrawn the moment reset asserts, not at the next clock edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCS_ALU;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_REG;
        alu_ctrl   = '0;
        retire     = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = ASB_ONE;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = ASB_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_ADDR, S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ASB_IMM;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    retire  = mem_ready;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = r_alu_ctrl;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = PCS_ALUOUT;
                    pc_write  = (opcode == OP_BNE) ? !zero : zero;
                    retire    = 1'b1;
                end
                S_JUMP: begin
                    pc_src   = PCS_JUMP;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
